dvp_config_master: RTL and testbench

DVP_CONFIG_MASTER -- requirements
Module: dvp_config_master

---
 rtl/dvp_config_master.sv | 215 +++++++++++++++++++++
 tb/tb_dvp_config_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_config_master.sv
// dvp_config_master: single-outstanding AXI4 master for register access.
// Turns one local read/write command into an AXI transaction and one rsp pulse.
module dvp_config_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MST_ID_W    = 5,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_wr_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [1:0]          rsp_resp_o,
    output logic [MST_ID_W-1:0] m_awid_o,
    output logic [ADDR_W-1:0]   m_awaddr_o,
    output logic                m_awvalid_o,
    input  logic                m_awready_i,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic                m_wvalid_o,
    input  logic                m_wready_i,
    input  logic [1:0]          m_bresp_i,
    input  logic                m_bvalid_i,
    output logic                m_bready_o,
    output logic [MST_ID_W-1:0] m_arid_o,
    output logic [ADDR_W-1:0]   m_araddr_o,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic [1:0]          m_rresp_i,
    input  logic                m_rvalid_i,
    output logic                m_rready_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RSP,
        S_RD_REQ,
        S_RD_RSP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_live;
    logic               r_awv;
    logic               r_wv;
    logic               r_arv;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_drain_b;
    logic               r_drain_r;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [1:0]         r_rsp_resp;

    logic               w_accept;
    logic               w_aw_done;
    logic               w_w_done;
    logic               w_tmo;
    logic               w_in_rsp;

    // r_live keeps cmd_ready low for the first cycle after reset release.
    assign cmd_ready_o = r_live && (r_state == S_IDLE)
                         && !r_drain_b && !r_drain_r;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_aw_done   = !r_awv || m_awready_i;
    assign w_w_done    = !r_wv || m_wready_i;
    assign w_in_rsp    = (r_state == S_WR_RSP) || (r_state == S_RD_RSP);
    assign w_tmo       = TMO_EN && w_in_rsp && (r_cnt == CNT_LAST);

    assign m_awid_o    = '0;
    assign m_arid_o    = '0;
    assign m_awaddr_o  = r_addr;
    assign m_araddr_o  = r_addr;
    assign m_wdata_o   = r_wdata;
    assign m_awvalid_o = r_awv;
    assign m_wvalid_o  = r_wv;
    assign m_arvalid_o = r_arv;
    // Drain flags keep accepting a late beat after a timeout.
    assign m_bready_o  = (r_state == S_WR_RSP) || r_drain_b;
    assign m_rready_o  = (r_state == S_RD_RSP) || r_drain_r;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_resp_o  = r_rsp_resp;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a response beat wins over a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = cmd_wr_i ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_aw_done && w_w_done) begin
                    w_state_nxt = S_WR_RSP;
                end
            end
            S_WR_RSP: begin
                if (m_bvalid_i || w_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (m_arready_i) begin
                    w_state_nxt = S_RD_RSP;
                end
            end
            S_RD_RSP: begin
                if (m_rvalid_i || w_tmo) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request channel valids and the latched command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_awv   <= 1'b0;
            r_wv    <= 1'b0;
            r_arv   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_addr  <= cmd_addr_i;
                r_wdata <= cmd_wr_i ? cmd_wdata_i : '0;
                r_awv   <= cmd_wr_i;
                r_wv    <= cmd_wr_i;
                r_arv   <= !cmd_wr_i;
            end else begin
                if (r_awv && m_awready_i) r_awv <= 1'b0;
                if (r_wv && m_wready_i)   r_wv  <= 1'b0;
                if (r_arv && m_arready_i) r_arv <= 1'b0;
            end
        end
    end

    // Response-phase timer: zero outside the response states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_in_rsp) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Completion pulse and drain flags for abandoned responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_drain_b   <= 1'b0;
            r_drain_r   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_drain_b && m_bvalid_i) r_drain_b <= 1'b0;
            if (r_drain_r && m_rvalid_i) r_drain_r <= 1'b0;
            if (r_state == S_WR_RSP) begin
                if (m_bvalid_i) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_resp  <= m_bresp_i;
                    r_rsp_rdata <= '0;
                end else if (w_tmo) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_resp  <= 2'b10;
                    r_rsp_rdata <= '0;
                    r_drain_b   <= 1'b1;
                end
            end
            if (r_state == S_RD_RSP) begin
                if (m_rvalid_i) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_resp  <= m_rresp_i;
                    r_rsp_rdata <= m_rdata_i;
                end else if (w_tmo) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_resp  <= 2'b10;
                    r_rsp_rdata <= '0;
                    r_drain_r   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_config_master.sv
// tb_dvp_config_master: directed stimulus with an AXI slave model.
// Expected responses are queued at issue and popped by a monitor.
module tb_dvp_config_master;

    localparam int TMO = 8;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_wr_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        cmd_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic [4:0]  m_awid_o;
    logic [31:0] m_awaddr_o;
    logic        m_awvalid_o;
    wire         m_awready_i;
    logic [31:0] m_wdata_o;
    logic        m_wvalid_o;
    wire         m_wready_i;
    logic [1:0]  m_bresp_i = 2'b00;
    logic        m_bvalid_i = 1'b0;
    logic        m_bready_o;
    logic [4:0]  m_arid_o;
    logic [31:0] m_araddr_o;
    logic        m_arvalid_o;
    wire         m_arready_i;
    logic [31:0] m_rdata_i = '0;
    logic [1:0]  m_rresp_i = 2'b00;
    logic        m_rvalid_i = 1'b0;
    logic        m_rready_o;

    int          cfg_aw_delay = 0;
    logic        cfg_b_hold = 1'b0;
    logic        cfg_ar_block = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    int          aw_cnt = 0;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_awv, n_wv, n_awhs, n_whs, n_bhs, n_rsp;
    int          b_cyc = 0, rsp_cyc = 0, ent_cyc = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic        prev_bready = 1'b0;

    always #5 clk = ~clk;

    assign m_awready_i = m_awvalid_o && (aw_cnt >= cfg_aw_delay);
    assign m_wready_i  = 1'b1;
    assign m_arready_i = !cfg_ar_block;

    dvp_config_master #(
        .ADDR_W(32), .DATA_W(32), .MST_ID_W(5), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wvalid_o(m_wvalid_o),
        .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
        .m_bready_o(m_bready_o),
        .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"},
            {cmd_ready_o, m_awvalid_o, m_wvalid_o, m_arvalid_o,
             m_bready_o, m_rready_o, rsp_valid_o, rsp_resp_o,
             m_awid_o, m_arid_o}, 64'd0);
        chk({tag, "_data"},
            m_awaddr_o | m_araddr_o | m_wdata_o | rsp_rdata_o, 64'd0);
    endtask

    task automatic clr_cnt();
        n_awv = 0; n_wv = 0; n_awhs = 0; n_whs = 0; n_bhs = 0; n_rsp = 0;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit push,
                         input logic [1:0] er, input logic [31:0] ed);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        if (push) begin
            e.resp  = er;
            e.rdata = ed;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scoreboard pops and handshake bookkeeping.
    initial begin
        exp_t e;
        clr_cnt();
        forever begin
            @(negedge clk);
            cyc++;
            if (m_awvalid_o) n_awv++;
            if (m_wvalid_o) n_wv++;
            if (m_awvalid_o && m_awready_i) begin
                n_awhs++;
                last_awaddr = m_awaddr_o;
            end
            if (m_wvalid_o && m_wready_i) begin
                n_whs++;
                last_wdata = m_wdata_o;
            end
            if (m_arvalid_o && m_arready_i) last_araddr = m_araddr_o;
            if (m_bvalid_i && m_bready_o) begin
                n_bhs++;
                b_cyc = cyc;
            end
            if (m_bready_o && !prev_bready) ent_cyc = cyc;
            prev_bready = m_bready_o;
            if (rst_n && rsp_valid_o) begin
                n_rsp++;
                rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_resp", 64'(rsp_resp_o), 64'(e.resp));
                    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                end
            end
        end
    end

    // AXI slave model with a small memory.
    initial begin
        logic        s_aw, s_w, s_b, s_ar, s_r, s_awv;
        logic [31:0] a, d, ra, wa, wd;
        logic        aw_got, w_got, b_pend, r_pend;
        logic [1:0]  b_q;
        logic [31:0] mem [logic [31:0]];
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        b_q = 0; wa = 0; wd = 0;
        forever begin
            @(negedge clk);
            s_aw  = m_awvalid_o && m_awready_i;
            s_w   = m_wvalid_o && m_wready_i;
            s_b   = m_bvalid_i && m_bready_o;
            s_ar  = m_arvalid_o && m_arready_i;
            s_r   = m_rvalid_i && m_rready_o;
            s_awv = m_awvalid_o;
            a     = m_awaddr_o;
            d     = m_wdata_o;
            ra    = m_araddr_o;
            @(posedge clk); #1;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0;
            end else begin
                if (s_aw) begin
                    aw_cnt = 0;
                    aw_got = 1;
                    wa = a;
                end else if (s_awv) begin
                    aw_cnt++;
                end
                if (s_w) begin
                    w_got = 1;
                    wd = d;
                end
                if (aw_got && w_got) begin
                    mem[wa] = wd;
                    aw_got = 0;
                    w_got = 0;
                    b_pend = 1;
                    b_q = cfg_bresp;
                end
                if (s_b) b_pend = 0;
                if (s_ar) begin
                    r_pend = 1;
                    m_rdata_i = mem.exists(ra) ? mem[ra] : 32'hDEAD_BEEF;
                end
                if (s_r) r_pend = 0;
            end
            m_bvalid_i = b_pend && !cfg_b_hold;
            m_bresp_i  = b_q;
            m_rvalid_i = r_pend;
            m_rresp_i  = 2'b00;
        end
    end

    // Directed sequence.
    initial begin
        bit ok;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_cycle", 64'(cmd_ready_o), 64'd0);
        @(negedge clk);
        chk("ready_after_release", 64'(cmd_ready_o), 64'd1);

        clr_cnt();
        issue(1'b1, 32'h4000_0004, 32'h1234_5678, 1'b1, 2'b00, 32'h0);
        wait_rsp();
        chk("wr_aw_beats", 64'(n_awhs), 64'd1);
        chk("wr_w_beats", 64'(n_whs), 64'd1);
        chk("wr_b_beats", 64'(n_bhs), 64'd1);
        chk("wr_awaddr", 64'(last_awaddr), 64'h4000_0004);
        chk("wr_wdata", 64'(last_wdata), 64'h1234_5678);
        chk("wr_rsp_latency", 64'(rsp_cyc - b_cyc), 64'd1);

        issue(1'b0, 32'h4000_0004, 32'h0, 1'b1, 2'b00, 32'h1234_5678);
        wait_rsp();
        chk("rd_araddr", 64'(last_araddr), 64'h4000_0004);

        cfg_bresp = 2'b11;
        issue(1'b1, 32'h4000_0010, 32'hCAFE_F00D, 1'b1, 2'b11, 32'h0);
        wait_rsp();
        cfg_bresp = 2'b00;

        cfg_aw_delay = 3;
        clr_cnt();
        issue(1'b1, 32'h4000_0020, 32'hA5A5_5A5A, 1'b1, 2'b00, 32'h0);
        wait_rsp();
        chk("dly_awvalid_cycles", 64'(n_awv), 64'd4);
        chk("dly_wvalid_cycles", 64'(n_wv), 64'd1);
        chk("dly_b_beats", 64'(n_bhs), 64'd1);
        chk("dly_rsp_count", 64'(n_rsp), 64'd1);
        cfg_aw_delay = 0;

        cfg_b_hold = 1'b1;
        clr_cnt();
        issue(1'b1, 32'h4000_0030, 32'h0BAD_BEEF, 1'b1, 2'b10, 32'h0);
        wait_rsp();
        chk("tmo_latency", 64'(rsp_cyc - ent_cyc), 64'(TMO));
        repeat (3) @(negedge clk);
        chk("tmo_ready_low", 64'(cmd_ready_o), 64'd0);
        chk("tmo_bready_drain", 64'(m_bready_o), 64'd1);
        @(posedge clk); #1;
        cfg_b_hold = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tmo_ready_back", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        chk("tmo_b_beats", 64'(n_bhs), 64'd1);
        chk("tmo_rsp_count", 64'(n_rsp), 64'd1);

        cfg_ar_block = 1'b1;
        issue(1'b0, 32'h4000_0008, 32'h0, 1'b0, 2'b00, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_arvalid_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_arvalid_seen", 64'(ok), 64'd1);
        chk("rst_araddr", 64'(m_araddr_o), 64'h4000_0008);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        clr_cnt();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_ar_block = 1'b0;
        issue(1'b0, 32'h4000_0004, 32'h0, 1'b1, 2'b00, 32'h1234_5678);
        wait_rsp();
        chk("rst_rsp_count", 64'(n_rsp), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
